// File: rtl/led_anim_sequencer.sv
// rtl/led_anim_sequencer.sv - frame sequencer from pattern ROM onto an active-low PWM-dimmed LED bar
module led_anim_sequencer #(
    parameter int ADDR_W   = 3,
    parameter int TICK_DIV = 16384,
    parameter int HOLD_W   = 8,
    parameter int PWM_W    = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic              STOP,
    input  logic              LOOP,
    input  logic [ADDR_W-1:0] FIRST,
    input  logic [ADDR_W-1:0] LAST,
    input  logic [HOLD_W-1:0] HOLD,
    input  logic [PWM_W-1:0]  BRIGHT,
    output logic [ADDR_W-1:0] ROM_ADDR,
    input  logic [7:0]        ROM_DATA,
    output logic [7:0]        LED_BAR,
    output logic              BUSY,
    output logic              FRAME_STB,
    output logic              DONE
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] first_q, first_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [PRE_W-1:0]  presc_q, presc_d;
    logic [7:0]        frame_q, frame_d;
    logic              stb_q, stb_d;
    logic              done_q, done_d;
    logic [PWM_W-1:0]  pwm_q;
    logic [7:0]        led_q;

    logic tick;
    logic busy;
    logic lit;

    assign tick = (presc_q == PRE_MAX);
    assign busy = (state_q != ST_IDLE);
    // BRIGHT all-ones forces full duty; otherwise lit for the first BRIGHT counts of each PWM period.
    assign lit  = (pwm_q < BRIGHT) | (&BRIGHT);

    // Next-state logic: start acceptance, frame fetch, hold timing and sequence walk.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        first_d    = first_q;
        last_d     = last_q;
        hold_d     = hold_q;
        hold_cnt_d = hold_cnt_q;
        presc_d    = presc_q;
        frame_d    = frame_q;
        stb_d      = 1'b0;
        done_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (START && !STOP) begin
                    first_d = FIRST;
                    last_d  = LAST;
                    hold_d  = HOLD;
                    addr_d  = FIRST;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (STOP) begin
                    state_d = ST_IDLE;
                end else begin
                    frame_d    = ROM_DATA;
                    stb_d      = 1'b1;
                    hold_cnt_d = (hold_q == '0) ? HOLD_W'(1) : hold_q;
                    presc_d    = '0;
                    state_d    = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (STOP) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    presc_d = '0;
                    if (hold_cnt_q == HOLD_W'(1)) begin
                        if (addr_q != last_q) begin
                            addr_d  = addr_q + ADDR_W'(1);
                            state_d = ST_FETCH;
                        end else if (LOOP) begin
                            addr_d  = first_q;
                            state_d = ST_FETCH;
                        end else begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                    end
                end else begin
                    presc_d = presc_q + PRE_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            first_q    <= '0;
            last_q     <= '0;
            hold_q     <= '0;
            hold_cnt_q <= '0;
            presc_q    <= '0;
            frame_q    <= '0;
            stb_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            first_q    <= first_d;
            last_q     <= last_d;
            hold_q     <= hold_d;
            hold_cnt_q <= hold_cnt_d;
            presc_q    <= presc_d;
            frame_q    <= frame_d;
            stb_q      <= stb_d;
            done_q     <= done_d;
        end
    end

    // Free-running PWM counter and registered active-low bar drive.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pwm_q <= '0;
            led_q <= 8'hFF;
        end else begin
            pwm_q <= pwm_q + PWM_W'(1);
            led_q <= busy ? ~(frame_q & {8{lit}}) : 8'hFF;
        end
    end

    assign ROM_ADDR  = addr_q;
    assign LED_BAR   = led_q;
    assign BUSY      = busy;
    assign FRAME_STB = stb_q;
    assign DONE      = done_q;

endmodule
